vault_access_sequencer: RTL and testbench
=========================================

// Module: vault_access_sequencer
// PURPOSE
//  Sequences vault access in the banking safety system; the successor to the combinational vault-open policy.
//  Collects credential pulses from President/VP1/VP2 within a time window and gates on guard presence.
//  Drives a timed unlock, raises an alarm if the door is left open, and locks out after repeated bad credentials.
//  Sits between the credential/keypad front end and the vault lock driver/LEDs.
// PARAMETERS
//  TICK_DIV      50_000_000  Clk cycles per timer tick (1 s at 50 MHz)
//  AUTH_WINDOW   30          ticks allowed to complete a dual-VP authorisation
//  OPEN_TIME     60          ticks vault stays unlocked
//  MAX_FAILS     3           bad credentials before lockout (1..15)
//  LOCKOUT_TIME  300         ticks spent in lockout
// PORTS
//  Clk               in   1  system clock
//  Reset             in   1  asynchronous, active-high reset
//  BankTiming        in   1  1 = open hours, 0 = closed hours
//  GaurdAvailability in   1  1 = guard present (level)
//  PresReq           in   1  1-cycle pulse: President credential valid
//  VP1Req            in   1  1-cycle pulse: VP1 credential valid
//  VP2Req            in   1  1-cycle pulse: VP2 credential valid
//  BadCred           in   1  1-cycle pulse: credential rejected
//  DoorClosed        in   1  1 = door sensor closed (level)
//  VaultUnlock       out  1  1 = lock released
//  Alarm             out  1  1 = door held open past OPEN_TIME
//  State             out  3  IDLE=0 COLLECT=1 UNLOCKED=2 ALARM=3 LOCKOUT=4
//  FailCount         out  4  consecutive bad credentials
// BEHAVIOUR
//  Reset: State=IDLE, VaultUnlock=0, Alarm=0, FailCount=0, VP latches, timers and prescaler cleared.
//  All outputs registered; an input sampled at edge t is reflected in outputs after edge t (1-cycle latency).
//  Prescaler: counts 0..TICK_DIV-1 and pulses tick at the wrap. Cleared on every state transition.
//  State timer: cleared on state entry, +1 per tick. Expiry = Nth tick in the state; the transition takes effect at that edge.
//  Grant condition G: Guard & (Pres | (BankTiming ? (vp1|vp2) : (vp1&vp2))).
//   vp1/vp2 = this-cycle pulse OR latched flag.
//  Per-cycle priority: BadCred > guard loss > grant > timer expiry.
//  IDLE:
//   - BadCred: FailCount+1. If the new value equals MAX_FAILS -> LOCKOUT.
//   - Else, any valid Req with guard: if G -> UNLOCKED; otherwise latch VP flag(s) -> COLLECT.
//   - A Req without guard is ignored.
//  COLLECT:
//   - BadCred: FailCount+1, latches cleared. -> LOCKOUT if MAX_FAILS reached, else -> IDLE.
//   - Guard low: latches cleared -> IDLE; FailCount unchanged.
//   - G: -> UNLOCKED.
//   - AUTH_WINDOW expiry: FailCount+1, latches cleared, -> IDLE (or -> LOCKOUT if MAX_FAILS reached).
//   - A repeated pulse from the same VP does not restart the window.
//  UNLOCKED:
//   - VaultUnlock=1, FailCount cleared on entry, latches cleared. Requests and BadCred ignored.
//   - OPEN_TIME expiry, or guard low: DoorClosed=1 -> IDLE (VaultUnlock=0); DoorClosed=0 -> ALARM.
//  ALARM: VaultUnlock=0, Alarm=1. Requests ignored. DoorClosed=1 -> IDLE, Alarm=0.
//  LOCKOUT:
//   - VaultUnlock=0. All Req/BadCred ignored; FailCount holds MAX_FAILS.
//   - LOCKOUT_TIME expiry -> IDLE, FailCount=0.
//  FailCount saturates at 15. BankTiming is sampled live each cycle; a change mid-COLLECT applies immediately.
//  Reset asserted in any state: immediate return to reset values; lock re-engages asynchronously.
// TESTING (TICK_DIV=4, AUTH_WINDOW=5, OPEN_TIME=8, MAX_FAILS=3, LOCKOUT_TIME=10)
//  1. BankTiming=1, Guard=1, VP1Req pulse -> VaultUnlock=1 next edge.
//     After 32 cycles with DoorClosed=1 -> State=IDLE, VaultUnlock=0.
//  2. BankTiming=0, Guard=1, VP1Req, then VP2Req 12 cycles later -> COLLECT, then UNLOCKED.
//     VP2Req at 21+ cycles -> window expiry at cycle 20 -> IDLE, FailCount=1.
//  3. Three BadCred pulses in IDLE -> State=LOCKOUT, FailCount=3.
//     PresReq during lockout has no effect. After 40 cycles -> IDLE, FailCount=0.
//  4. UNLOCKED with DoorClosed=0 at OPEN_TIME expiry -> State=ALARM, Alarm=1, VaultUnlock=0.
//     DoorClosed=1 -> IDLE, Alarm=0.
//  5. BadCred and PresReq in the same cycle (Guard=1) -> no unlock, FailCount+1.
//     Guard low mid-COLLECT -> IDLE, FailCount unchanged.
//  6. Reset pulse mid-UNLOCKED -> VaultUnlock=0 asynchronously, State=IDLE, FailCount=0.

Source files
------------

// File: rtl/vault_access_sequencer.sv
// Vault access sequencer: collects President/VP credentials under guard presence,
// drives a timed unlock, raises a door-held-open alarm and locks out after repeated bad credentials.
module vault_access_sequencer #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int AUTH_WINDOW  = 30,
    parameter int OPEN_TIME    = 60,
    parameter int MAX_FAILS    = 3,
    parameter int LOCKOUT_TIME = 300
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       BankTiming,
    input  logic       GaurdAvailability,
    input  logic       PresReq,
    input  logic       VP1Req,
    input  logic       VP2Req,
    input  logic       BadCred,
    input  logic       DoorClosed,
    output logic       VaultUnlock,
    output logic       Alarm,
    output logic [2:0] State,
    output logic [3:0] FailCount
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        UNLOCKED = 3'd2,
        ALARM    = 3'd3,
        LOCKOUT  = 3'd4
    } stateT;

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMAX_A = (AUTH_WINDOW > OPEN_TIME) ? AUTH_WINDOW : OPEN_TIME;
    localparam int TMAX   = (TMAX_A > LOCKOUT_TIME) ? TMAX_A : LOCKOUT_TIME;
    localparam int TMR_W  = $clog2(TMAX + 1);

    stateT            stateReg, stateNext;
    logic [PRE_W-1:0] preCntReg;
    logic [TMR_W-1:0] timerReg;
    logic             vp1Reg, vp1Next;
    logic             vp2Reg, vp2Next;
    logic [3:0]       failReg, failNext;
    logic             unlockReg, alarmReg;

    logic       tick;
    logic       windowExp, openExp, lockExp;
    logic       vp1, vp2, grant, anyReq;
    logic [3:0] failInc;
    logic       reachedMax;

    assign tick      = (preCntReg == PRE_W'(TICK_DIV - 1));
    // Expiry is the Nth tick since entry: the timer still reads N-1 at that edge.
    assign windowExp = tick && (timerReg == TMR_W'(AUTH_WINDOW - 1));
    assign openExp   = tick && (timerReg == TMR_W'(OPEN_TIME - 1));
    assign lockExp   = tick && (timerReg == TMR_W'(LOCKOUT_TIME - 1));

    assign vp1     = VP1Req | vp1Reg;
    assign vp2     = VP2Req | vp2Reg;
    assign grant   = GaurdAvailability & (PresReq | (BankTiming ? (vp1 | vp2) : (vp1 & vp2)));
    assign anyReq  = PresReq | VP1Req | VP2Req;

    assign failInc    = (failReg == 4'd15) ? 4'd15 : failReg + 4'd1;
    assign reachedMax = (failInc == 4'(MAX_FAILS));

    always_comb begin
        stateNext = stateReg;
        vp1Next   = vp1Reg;
        vp2Next   = vp2Reg;
        failNext  = failReg;
        case (stateReg)
            IDLE: begin
                if (BadCred) begin
                    failNext = failInc;
                    if (reachedMax) stateNext = LOCKOUT;
                end else if (GaurdAvailability && anyReq) begin
                    if (grant) begin
                        stateNext = UNLOCKED;
                        failNext  = 4'd0;
                    end else begin
                        vp1Next   = VP1Req;
                        vp2Next   = VP2Req;
                        stateNext = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (BadCred || (GaurdAvailability && !grant && windowExp)) begin
                    failNext  = failInc;
                    vp1Next   = 1'b0;
                    vp2Next   = 1'b0;
                    stateNext = reachedMax ? LOCKOUT : IDLE;
                end else if (!GaurdAvailability) begin
                    vp1Next   = 1'b0;
                    vp2Next   = 1'b0;
                    stateNext = IDLE;
                end else if (grant) begin
                    vp1Next   = 1'b0;
                    vp2Next   = 1'b0;
                    failNext  = 4'd0;
                    stateNext = UNLOCKED;
                end else begin
                    // Latching a repeat pulse leaves the window timer untouched.
                    vp1Next = vp1;
                    vp2Next = vp2;
                end
            end
            UNLOCKED: begin
                if (openExp || !GaurdAvailability)
                    stateNext = DoorClosed ? IDLE : ALARM;
            end
            ALARM: begin
                if (DoorClosed) stateNext = IDLE;
            end
            LOCKOUT: begin
                if (lockExp) begin
                    stateNext = IDLE;
                    failNext  = 4'd0;
                end
            end
            default: begin
                stateNext = IDLE;
                vp1Next   = 1'b0;
                vp2Next   = 1'b0;
                failNext  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stateReg  <= IDLE;
            preCntReg <= '0;
            timerReg  <= '0;
            vp1Reg    <= 1'b0;
            vp2Reg    <= 1'b0;
            failReg   <= 4'd0;
            unlockReg <= 1'b0;
            alarmReg  <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            vp1Reg    <= vp1Next;
            vp2Reg    <= vp2Next;
            failReg   <= failNext;
            unlockReg <= (stateNext == UNLOCKED);
            alarmReg  <= (stateNext == ALARM);
            if (stateNext != stateReg) begin
                preCntReg <= '0;
                timerReg  <= '0;
            end else begin
                preCntReg <= tick ? '0 : preCntReg + PRE_W'(1);
                if (tick) timerReg <= timerReg + TMR_W'(1);
            end
        end
    end

    assign State       = stateReg;
    assign FailCount   = failReg;
    assign VaultUnlock = unlockReg;
    assign Alarm       = alarmReg;

endmodule

// File: tb/tb_vault_access_sequencer.sv
// Randomized bench for vault_access_sequencer against a cycles-since-entry reference model.
module tb_vault_access_sequencer;

    localparam int TD  = 4;
    localparam int AW  = 5;
    localparam int OT  = 8;
    localparam int MF  = 3;
    localparam int LT  = 10;

    localparam int S_IDLE = 0, S_COL = 1, S_UNL = 2, S_ALM = 3, S_LOCK = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       BankTiming = 1'b0, GaurdAvailability = 1'b0;
    logic       PresReq = 1'b0, VP1Req = 1'b0, VP2Req = 1'b0, BadCred = 1'b0;
    logic       DoorClosed = 1'b1;
    logic       VaultUnlock, Alarm;
    logic [2:0] State;
    logic [3:0] FailCount;

    int assertCount = 0;
    int failTotal   = 0;
    int cycleNum    = 0;

    // Reference model state
    int mState, mAge, mFail;
    bit mVp1, mVp2;

    vault_access_sequencer #(
        .TICK_DIV(TD), .AUTH_WINDOW(AW), .OPEN_TIME(OT),
        .MAX_FAILS(MF), .LOCKOUT_TIME(LT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .BankTiming(BankTiming),
        .GaurdAvailability(GaurdAvailability), .PresReq(PresReq),
        .VP1Req(VP1Req), .VP2Req(VP2Req), .BadCred(BadCred),
        .DoorClosed(DoorClosed), .VaultUnlock(VaultUnlock), .Alarm(Alarm),
        .State(State), .FailCount(FailCount)
    );

    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input int got, input int exp);
        assertCount++;
        if (got != exp) begin
            failTotal++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cycleNum, got, exp);
        end
    endtask

    task automatic modelReset();
        mState = S_IDLE; mAge = 0; mFail = 0; mVp1 = 0; mVp2 = 0;
    endtask

    // Timed states expire exactly N*TICK_DIV cycles after the entry edge.
    task automatic modelStep(input bit bt, g, p, v1r, v2r, bc, dc);
        int age, ns, inc;
        bit v1, v2, grant, expired;
        age   = mAge + 1;
        ns    = mState;
        v1    = v1r | mVp1;
        v2    = v2r | mVp2;
        grant = g && (p || (bt ? (v1 || v2) : (v1 && v2)));
        inc   = (mFail < 15) ? mFail + 1 : 15;
        case (mState)
            S_IDLE: begin
                if (bc) begin
                    mFail = inc;
                    if (inc == MF) ns = S_LOCK;
                end else if (g && (p || v1r || v2r)) begin
                    if (grant) ns = S_UNL;
                    else begin mVp1 = v1r; mVp2 = v2r; ns = S_COL; end
                end
            end
            S_COL: begin
                expired = (age == AW * TD);
                if (bc) begin
                    mFail = inc; ns = (inc == MF) ? S_LOCK : S_IDLE;
                end else if (!g) ns = S_IDLE;
                else if (grant) ns = S_UNL;
                else if (expired) begin
                    mFail = inc; ns = (inc == MF) ? S_LOCK : S_IDLE;
                end else begin
                    mVp1 = v1; mVp2 = v2;
                end
            end
            S_UNL: begin
                if (age == OT * TD || !g) ns = dc ? S_IDLE : S_ALM;
            end
            S_ALM: if (dc) ns = S_IDLE;
            S_LOCK: if (age == LT * TD) begin ns = S_IDLE; mFail = 0; end
            default: ns = S_IDLE;
        endcase
        if (ns == S_UNL && mState != S_UNL) mFail = 0;
        if (ns != S_COL) begin mVp1 = 0; mVp2 = 0; end
        mAge   = (ns != mState) ? 0 : age;
        mState = ns;
    endtask

    task automatic checkOutputs();
        checkVal("State", int'(State), mState);
        checkVal("VaultUnlock", int'(VaultUnlock), (mState == S_UNL) ? 1 : 0);
        checkVal("Alarm", int'(Alarm), (mState == S_ALM) ? 1 : 0);
        checkVal("FailCount", int'(FailCount), mFail);
    endtask

    // Called at a negedge: drive one cycle of inputs, model the edge, check at the next negedge.
    task automatic step(input bit bt, g, p, v1, v2, bc, dc);
        BankTiming = bt; GaurdAvailability = g; PresReq = p;
        VP1Req = v1; VP2Req = v2; BadCred = bc; DoorClosed = dc;
        @(posedge Clk);
        modelStep(bt, g, p, v1, v2, bc, dc);
        @(negedge Clk);
        cycleNum++;
        if (p || v1 || v2 || bc)
            $display("cyc %0d bt=%0b g=%0b P=%0b V1=%0b V2=%0b bad=%0b dc=%0b -> state=%0d fail=%0d unlock=%0b",
                     cycleNum, bt, g, p, v1, v2, bc, dc, State, FailCount, VaultUnlock);
        checkOutputs();
    endtask

    function automatic bit chance(input int n);
        return ($urandom_range(n - 1) == 0);
    endfunction

    initial begin
        bit bt, g, dc;
        modelReset();
        repeat (2) @(negedge Clk);
        checkOutputs();
        Reset = 1'b0;

        // Three bad credentials, ignored PresReq, then lockout expiry
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 44; i++) step(1, 1, (i == 5), 0, 0, 0, 1);

        // Closed hours: VP1 alone, window lapses, late VP2 starts a new collect
        step(0, 1, 0, 1, 0, 0, 1);
        for (int i = 0; i < 22; i++) step(0, 1, 0, 0, (i == 20), 0, 1);
        for (int i = 0; i < 25; i++) step(0, 1, 0, (i == 11), 0, 0, 1);

        // Unlock then leave door open past OPEN_TIME
        step(1, 1, 0, 1, 0, 0, 1);
        for (int i = 0; i < 36; i++) step(1, 1, 0, 0, 0, 0, (i > 33));

        // Randomized traffic
        bt = 1; g = 1; dc = 1;
        for (int i = 0; i < 4000; i++) begin
            if (chance(50)) bt = ~bt;
            if (g ? chance(80) : chance(6)) g = ~g;
            if (chance(30)) dc = ~dc;
            step(bt, g, chance(40), chance(20), chance(20), chance(45), dc);
        end

        // Asynchronous reset in the middle of an unlock
        step(1, 1, 0, 0, 0, 1, 1);
        while (mState != S_IDLE) step(1, 1, 0, 0, 0, 0, 1);
        step(1, 1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 1);
        #2 Reset = 1'b1;
        #1;
        checkVal("AsyncUnlock", int'(VaultUnlock), 0);
        checkVal("AsyncState", int'(State), S_IDLE);
        checkVal("AsyncFail", int'(FailCount), 0);
        modelReset();
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) step(1, 1, (i == 1), 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failTotal);
        $finish;
    end

endmodule
